qsfp_mgmt_ctrl: RTL

QSFP_MGMT_CTRL -- requirements
Module: qsfp_mgmt_ctrl

---
 rtl/qsfp_mgmt_ctrl_if.sv | 43 ++++
 rtl/qsfp_mgmt_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsfp_mgmt_ctrl_if.sv
// wb_interface: Wishbone classic register bus used by qsfp_mgmt_ctrl.
//
// Signals:
//   adr   [7:0]  register address (the block decodes all eight bits)
//   dat_i [31:0] write data from the master
//   dat_o [31:0] read data from the slave, valid in the ack cycle
//   we           write enable
//   stb, cyc     strobe and cycle
//   ack          single-cycle acknowledge from the slave
//
// Handshake: a transfer is requested while cyc & stb are high. The slave
// answers with ack high for exactly one cycle. The master removes or changes
// the request after seeing ack. A request held high across the ack gets a
// fresh ack two cycles later.
interface wb_interface;
    logic [7:0]  adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;

    modport slave (
        input  adr,
        input  dat_i,
        input  we,
        input  stb,
        input  cyc,
        output dat_o,
        output ack
    );

    modport master (
        output adr,
        output dat_i,
        output we,
        output stb,
        output cyc,
        input  dat_o,
        input  ack
    );
endinterface

// File: rtl/qsfp_mgmt_ctrl.sv
// qsfp_mgmt_ctrl: QSFP module management controller.
//
// This block debounces module presence, sequences module reset and
// initialisation, latches the module interrupt, and exposes control and
// status through a small Wishbone register file.
//
// Ports:
//   clk          single clock for all logic, including the register bus
//   rst_n        asynchronous active-low reset (release synchronized inside)
//   wb           Wishbone slave (adr, dat_i, dat_o, we, stb, cyc, ack)
//   modprs_b     module present pin, asynchronous, active-low
//   int_b        module interrupt pin, asynchronous, active-low
//   modsel_b     module select, active-low
//   reset_b      module reset, active-low
//   lp_mode      module low-power request
//   module_ready high only in READY
//   irq          level interrupt = int_latched & irq_en
//
// Registers (adr[7:0]):
//   0x00 CTRL       bit0 enable, bit1 lp_force, bit2 soft_reset (pulse, reads 0), bit3 irq_en
//   0x01 STATUS     bits[1:0] state, bit2 present, bit3 int, bit4 int_latched (W1C)
//   0x02 INSERT_CNT bits[15:0], any write clears it
//   0x03 ID         0x51F0_0001
//   other           read 0, writes ignored
module qsfp_mgmt_ctrl #(
    parameter int T_RESET_CYC  = 2000,
    parameter int T_INIT_CYC   = 400000000,
    parameter int DEBOUNCE_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_interface.slave wb,
    input  logic       modprs_b,
    input  logic       int_b,
    output logic       modsel_b,
    output logic       reset_b,
    output logic       lp_mode,
    output logic       module_ready,
    output logic       irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_INIT  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    localparam int          DB_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [31:0] ID_VALUE = 32'h51F0_0001;

    // Reset assertion is asynchronous everywhere; release only takes effect
    // once 'run' rises, two clean edges after rst_n goes high. Until then
    // every register holds the value the asynchronous reset gave it.
    logic [1:0] rst_sync;
    logic       run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign run = rst_sync[1];

    // Pin synchronizers, reset to 1 so the module looks absent and quiet.
    logic [1:0] prs_sync;
    logic [1:0] int_sync;
    logic       sync_prs_b;
    logic       sync_int_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prs_sync <= 2'b11;
            int_sync <= 2'b11;
        end else if (run) begin
            prs_sync <= {prs_sync[0], modprs_b};
            int_sync <= {int_sync[0], int_b};
        end
    end

    assign sync_prs_b = prs_sync[1];
    assign sync_int_b = int_sync[1];

    // Register bus decode. A request is accepted when ack is low, so a held
    // request alternates request/ack cycles and never writes twice.
    logic wb_req;
    logic wr_ctrl;
    logic wr_status;
    logic wr_cnt;
    logic soft_reset;
    logic int_clear;
    logic unused_dat;

    assign wb_req     = wb.cyc & wb.stb & ~wb.ack;
    assign wr_ctrl    = wb_req & wb.we & (wb.adr == 8'h00);
    assign wr_status  = wb_req & wb.we & (wb.adr == 8'h01);
    assign wr_cnt     = wb_req & wb.we & (wb.adr == 8'h02);
    assign soft_reset = wr_ctrl & wb.dat_i[2];
    assign int_clear  = wr_status & wb.dat_i[4];
    assign unused_dat = ^wb.dat_i[31:5];

    // CTRL register
    logic enable;
    logic lp_force;
    logic irq_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable   <= 1'b0;
            lp_force <= 1'b1;
            irq_en   <= 1'b0;
        end else if (run && wr_ctrl) begin
            enable   <= wb.dat_i[0];
            lp_force <= wb.dat_i[1];
            irq_en   <= wb.dat_i[3];
        end
    end

    // Presence debounce: 'present' follows the synchronized pin only after
    // it has disagreed for DEBOUNCE_CYC consecutive cycles.
    logic            present;
    logic [DB_W-1:0] db_cnt;
    logic            db_differs;
    logic            db_done;
    logic [15:0]     insert_cnt;

    assign db_differs = (~sync_prs_b) != present;
    assign db_done    = db_differs && (db_cnt == DB_W'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            present <= 1'b0;
            db_cnt  <= '0;
        end else if (run) begin
            if (!db_differs) begin
                db_cnt <= '0;
            end else if (db_done) begin
                present <= ~sync_prs_b;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Insertion counter counts accepted 0->1 presence changes, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insert_cnt <= '0;
        end else if (run) begin
            if (wr_cnt)
                insert_cnt <= '0;
            else if (db_done && !present && insert_cnt != 16'hFFFF)
                insert_cnt <= insert_cnt + 16'd1;
        end
    end

    // Bring-up FSM
    state_t      state_q;
    state_t      state_d;
    logic [31:0] timer;
    logic [31:0] timer_d;
    logic        restart;

    assign restart = soft_reset && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer   <= '0;
        end else if (run) begin
            state_q <= state_d;
            timer   <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!present || !enable) begin
            state_d = ST_IDLE;
        end else if (restart) begin
            state_d = ST_RESET;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_RESET;
                ST_RESET: if (timer == 32'(T_RESET_CYC - 1)) state_d = ST_INIT;
                ST_INIT:  if (timer == 32'(T_INIT_CYC - 1))  state_d = ST_READY;
                default:  state_d = ST_READY;
            endcase
        end

        // The timer counts cycles spent in the current state and restarts on
        // every state change or soft reset.
        timer_d = timer + 32'd1;
        if (state_d != state_q || restart)
            timer_d = '0;
    end

    always_comb begin
        reset_b      = 1'b0;
        lp_mode      = 1'b1;
        modsel_b     = 1'b1;
        module_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                reset_b = 1'b1;
            end
            ST_READY: begin
                reset_b      = 1'b1;
                modsel_b     = 1'b0;
                lp_mode      = lp_force;
                module_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Interrupt latch: a new interrupt wins over a simultaneous clear.
    logic int_latched;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_latched <= 1'b0;
        end else if (run) begin
            if (!sync_int_b && state_q == ST_READY)
                int_latched <= 1'b1;
            else if (int_clear)
                int_latched <= 1'b0;
        end
    end

    assign irq = int_latched & irq_en;

    // Read mux and registered response
    logic [31:0] rdata;
    logic        ack_q;
    logic [31:0] dat_q;

    always_comb begin
        rdata = '0;
        case (wb.adr)
            8'h00: rdata = {28'd0, irq_en, 1'b0, lp_force, enable};
            8'h01: rdata = {27'd0, int_latched, ~sync_int_b, present, state_q};
            8'h02: rdata = {16'd0, insert_cnt};
            8'h03: rdata = ID_VALUE;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else if (run) begin
            ack_q <= wb_req;
            dat_q <= (wb_req && !wb.we) ? rdata : '0;
        end
    end

    assign wb.ack   = ack_q;
    assign wb.dat_o = dat_q;

endmodule
